// File: rtl/dvp_frame_writer.sv
// rtl/dvp_frame_writer.sv - buffers RGB565 pixels and issues fixed-length burst writes per frame
module dvp_frame_writer #(
    parameter int BURST_LEN    = 64,
    parameter int FIFO_DEPTH   = 256,
    parameter int FRAME_PIXELS = 307200,
    parameter int ADDR_W       = 20,
    parameter int BASE_ADDR    = 0
) (
    input  logic                        sclk,         // system clock
    input  logic                        rst,          // synchronous, active-high
    input  logic                        frame_start,  // start-of-frame pulse
    input  logic                        pix_valid,    // pixel strobe
    input  logic [15:0]                 pix_data,     // RGB565 pixel
    output logic                        wr_req,       // burst request, held until wr_ack
    output logic [ADDR_W-1:0]           wr_addr,      // burst start word address
    input  logic                        wr_ack,       // request accepted
    input  logic                        wr_data_rd,   // controller pops one word
    output logic [15:0]                 wr_data,      // FIFO head, registered show-ahead
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,   // FIFO occupancy
    output logic                        overflow,     // sticky pixel-dropped-on-full flag
    output logic                        frame_done    // one-cycle end-of-frame pulse
);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int LW     = PW + 1;
    localparam int NBURST = FRAME_PIXELS / BURST_LEN;
    localparam int CW     = $clog2(FRAME_PIXELS + 1);
    localparam int BW     = $clog2(NBURST + 1);
    localparam int KW     = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_REQ, S_XFER, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [LW-1:0]   level_q, level_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d;
    logic [BW-1:0]   burst_idx_q, burst_idx_d;
    logic [KW-1:0]   pop_cnt_q, pop_cnt_d;
    logic            pending_q, pending_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     head_q, head_d;
    logic [15:0]     mem_q [FIFO_DEPTH];

    logic accepting, full, in_room, push, pop, last_pop, restart;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        in_cnt_d    = in_cnt_q;
        burst_idx_d = burst_idx_q;
        pop_cnt_d   = pop_cnt_q;
        pending_d   = pending_q;
        overflow_d  = overflow_q;
        head_d      = head_q;
        restart     = 1'b0;
        rd_next     = rd_ptr_q + PW'(1);

        // Once a restart is pending, the rest of the old frame is discarded.
        accepting = (state_q == S_FILL || state_q == S_REQ || state_q == S_XFER) && !pending_q;
        full      = (level_q == LW'(FIFO_DEPTH));
        in_room   = (in_cnt_q < CW'(FRAME_PIXELS));
        pop       = (state_q == S_XFER) && wr_data_rd && (level_q != '0);
        last_pop  = pop && (pop_cnt_q == KW'(BURST_LEN - 1));

        case (state_q)
            S_IDLE: if (frame_start) restart = 1'b1;
            S_FILL: begin
                if (frame_start) restart = 1'b1;
                else if (level_q >= LW'(BURST_LEN)) state_d = S_REQ;
            end
            S_REQ: begin
                if (frame_start) pending_d = 1'b1;
                if (wr_ack) state_d = S_XFER;
            end
            S_XFER: begin
                if (frame_start) pending_d = 1'b1;
                if (last_pop) begin
                    if (pending_q || frame_start) restart = 1'b1;
                    else if (burst_idx_q == BW'(NBURST - 1)) state_d = S_DONE;
                    else state_d = S_FILL;
                end
            end
            S_DONE: begin
                if (frame_start) restart = 1'b1;
                else state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        push = accepting && pix_valid && !full && in_room && !restart;

        if (accepting && pix_valid && full && in_room) overflow_d = 1'b1;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            in_cnt_d = in_cnt_q + CW'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_next;
            pop_cnt_d = last_pop ? '0 : pop_cnt_q + KW'(1);
        end
        if (last_pop) burst_idx_d = burst_idx_q + BW'(1);
        level_d = level_q + LW'(push) - LW'(pop);

        // Show-ahead head: a pushed pixel becomes the head only when it lands
        // in a FIFO that is (or is about to become) empty.
        if (push && (level_q == '0 || (pop && level_q == LW'(1)))) head_d = pix_data;
        else if (pop && level_q > LW'(1)) head_d = mem_q[rd_next];

        if (restart) begin
            state_d     = S_FILL;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            in_cnt_d    = '0;
            burst_idx_d = '0;
            pop_cnt_d   = '0;
            pending_d   = 1'b0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_cnt_q    <= '0;
            burst_idx_q <= '0;
            pop_cnt_q   <= '0;
            pending_q   <= 1'b0;
            overflow_q  <= 1'b0;
            head_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_cnt_q    <= in_cnt_d;
            burst_idx_q <= burst_idx_d;
            pop_cnt_q   <= pop_cnt_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            head_q      <= head_d;
        end
    end

    always_ff @(posedge sclk) begin
        if (push) mem_q[wr_ptr_q] <= pix_data;
    end

    assign wr_req     = (state_q == S_REQ);
    assign wr_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(burst_idx_q * BURST_LEN);
    assign wr_data    = head_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign frame_done = (state_q == S_DONE);
endmodule

// File: tb/tb_dvp_frame_writer.sv
// tb/tb_dvp_frame_writer.sv - randomized self-checking bench for dvp_frame_writer
module tb_dvp_frame_writer;
    localparam int BL    = 64;
    localparam int DEPTH = 256;
    localparam int FRAME = 512;
    localparam int AW    = 20;
    localparam int BASE  = 0;

    logic          sclk = 1'b0;
    logic          rst, frame_start, pix_valid, wr_ack, wr_data_rd;
    logic [15:0]   pix_data;
    logic          wr_req, overflow, frame_done;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [8:0]    fifo_level;

    dvp_frame_writer #(
        .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FRAME), .ADDR_W(AW), .BASE_ADDR(BASE)
    ) dut (
        .sclk(sclk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_data(pix_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
        .wr_data_rd(wr_data_rd), .wr_data(wr_data), .fifo_level(fifo_level),
        .overflow(overflow), .frame_done(frame_done)
    );

    always #5 sclk = ~sclk;

    int checks = 0;
    int failures = 0;

    // Reference model: pixel queue plus the frame progress the rules describe.
    logic [15:0] q[$];
    int  m_in, m_bidx, m_pops;
    bit  m_busy, m_req, m_xfer, m_done, m_pend, m_ovf;

    int  req_rises, done_cnt;
    bit  prev_req;
    logic [31:0] addr_log[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_new_frame();
        q.delete();
        m_in = 0; m_bidx = 0; m_pops = 0;
        m_pend = 0; m_ovf = 0;
        m_busy = 1; m_req = 0; m_xfer = 0; m_done = 0;
    endtask

    task automatic step(bit r, bit pv, logic [15:0] pd, bit fs, bit ack, bit rd);
        bit restart, pop, full, fill, drop_ok;
        int sz;
        rst = r; pix_valid = pv; pix_data = pd; frame_start = fs; wr_ack = ack; wr_data_rd = rd;
        sz   = q.size();
        fill = m_busy && !m_req && !m_xfer;
        pop  = m_xfer && rd && (sz > 0);
        if (pop) check("pop_data", wr_data, q[0]);
        if (r) begin
            q.delete();
            m_in = 0; m_bidx = 0; m_pops = 0;
            m_busy = 0; m_req = 0; m_xfer = 0; m_done = 0; m_pend = 0; m_ovf = 0;
        end else begin
            restart = fs && !m_req && !m_xfer;
            full    = (sz >= DEPTH);
            drop_ok = m_busy && !m_pend && pv && (m_in < FRAME) && !restart;
            if (drop_ok && full) m_ovf = 1;
            if (pop) void'(q.pop_front());
            if (drop_ok && !full) begin
                q.push_back(pd);
                m_in++;
            end
            if (restart) model_new_frame();
            else if (m_done) m_done = 0;
            else if (fill) begin
                if (sz >= BL) m_req = 1;
            end else if (m_req) begin
                if (fs) m_pend = 1;
                if (ack) begin m_req = 0; m_xfer = 1; end
            end else if (m_xfer) begin
                if (fs) m_pend = 1;
                if (pop) begin
                    m_pops++;
                    if (m_pops == BL) begin
                        m_pops = 0; m_bidx++; m_xfer = 0;
                        if (m_pend) model_new_frame();
                        else if (m_bidx * BL == FRAME) begin m_busy = 0; m_done = 1; end
                    end
                end
            end
        end
        @(posedge sclk);
        #1;
        check("wr_req", 32'(wr_req), 32'(m_req));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("frame_done", 32'(frame_done), 32'(m_done));
        if (m_req) check("wr_addr", 32'(wr_addr), 32'((BASE + m_bidx * BL) % (1 << AW)));
        if (q.size() > 0) check("wr_data", 32'(wr_data), 32'(q[0]));
        if (wr_req && !prev_req) begin
            req_rises++;
            addr_log.push_back(32'(wr_addr));
        end
        prev_req = wr_req;
        if (frame_done) done_cnt++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 0, 0);
    endtask

    initial begin
        int budget;
        logic [15:0] exp_next;
        rst = 1; frame_start = 0; pix_valid = 0; pix_data = 0; wr_ack = 0; wr_data_rd = 0;
        prev_req = 0; req_rises = 0; done_cnt = 0;

        // Reset state
        step(1, 0, 16'h0, 0, 0, 0);
        step(1, 1, 16'h1234, 0, 0, 0);
        check("rst_wr_addr", 32'(wr_addr), 32'(BASE));
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        step(0, 1, 16'(
            $urandom), 0, 0, 1);
        check("idle_ignores_pixels", 32'(fifo_level), 32'h0);

        // First burst with a ramp, then the rest of the frame randomized
        req_rises = 0; done_cnt = 0; addr_log.delete();
        step(0, 0, 16'h0, 1, 0, 0);
        for (int i = 0; i < BL; i++) step(0, 1, 16'(i), 0, 0, 0);
        check("t1_no_req_yet", 32'(wr_req), 32'h0);
        step(0, 0, 16'h0, 0, 0, 0);
        check("t1_req", 32'(wr_req), 32'h1);
        check("t1_addr", 32'(wr_addr), 32'(BASE));
        step(0, 0, 16'h0, 0, 1, 0);
        for (int i = 0; i < BL; i++) step(0, 0, 16'h0, 0, 0, 1);
        budget = 0;
        while (done_cnt == 0 && budget < 20000) begin
            step(0, ($urandom % 4) != 0, 16'($urandom), 0,
                 m_req && (($urandom % 3) == 0), ($urandom % 4) != 0);
            budget++;
        end
        check("t2_done_seen", 32'(done_cnt), 32'h1);
        idle(3);
        step(0, 1, 16'($urandom), 0, 0, 0);
        check("t2_done_pulses", 32'(done_cnt), 32'h1);
        check("t2_bursts", 32'(req_rises), 32'(FRAME / BL));
        for (int k = 0; k < FRAME / BL; k++)
            if (k < addr_log.size()) check("t2_burst_addr", addr_log[k], 32'(BASE + k * BL));

        // Overflow with wr_ack held low, then a pending restart clears it
        step(0, 0, 16'h0, 1, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 16'($urandom), 0, 0, 0);
        check("t3_level", 32'(fifo_level), 32'(DEPTH));
        check("t3_overflow", 32'(overflow), 32'h1);
        step(0, 1, 16'($urandom), 1, 0, 0);
        check("t3_ovf_held", 32'(overflow), 32'h1);
        step(0, 0, 16'h0, 0, 1, 0);
        for (int i = 0; i < BL; i++) step(0, 1, 16'($urandom), 0, 0, 1);
        check("t3_ovf_cleared", 32'(overflow), 32'h0);
        check("t3_flushed", 32'(fifo_level), 32'h0);

        // frame_start during burst 1 transfer
        done_cnt = 0;
        for (int i = 0; i < 2 * BL; i++) step(0, 1, 16'($urandom), 0, 0, 0);
        step(0, 0, 16'h0, 0, 1, 0);
        for (int i = 0; i < BL; i++) step(0, 0, 16'h0, 0, 0, 1);
        step(0, 0, 16'h0, 0, 0, 0);
        check("t4_addr1", 32'(wr_addr), 32'(BASE + BL));
        step(0, 0, 16'h0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 16'h0, 0, 0, 1);
        step(0, 0, 16'h0, 1, 0, 1);
        for (int i = 0; i < BL - 11; i++) step(0, 1, 16'($urandom), 0, 0, 1);
        check("t4_no_done", 32'(done_cnt), 32'h0);
        check("t4_flushed", 32'(fifo_level), 32'h0);
        for (int i = 0; i < BL; i++) step(0, 1, 16'($urandom), 0, 0, 0);
        step(0, 0, 16'h0, 0, 0, 0);
        check("t4_restart_req", 32'(wr_req), 32'h1);
        check("t4_restart_addr", 32'(wr_addr), 32'(BASE));

        // Simultaneous push and pop at level 10
        step(0, 0, 16'h0, 0, 1, 0);
        for (int i = 0; i < BL - 10; i++) step(0, 0, 16'h0, 0, 0, 1);
        check("t5_level_before", 32'(fifo_level), 32'd10);
        exp_next = q[1];
        step(0, 1, 16'($urandom), 0, 0, 1);
        check("t5_level_after", 32'(fifo_level), 32'd10);
        check("t5_head_advanced", 32'(wr_data), 32'(exp_next));

        // Reset while a request is outstanding
        for (int i = 0; i < 9; i++) step(0, 0, 16'h0, 0, 0, 1);
        for (int i = 0; i < BL - 1; i++) step(0, 1, 16'($urandom), 0, 0, 0);
        step(0, 0, 16'h0, 0, 0, 0);
        check("t6_req_mid", 32'(wr_req), 32'h1);
        step(1, 0, 16'h0, 0, 0, 0);
        check("t6_rst_req", 32'(wr_req), 32'h0);
        check("t6_rst_level", 32'(fifo_level), 32'h0);
        step(0, 0, 16'h0, 1, 0, 0);
        for (int i = 0; i < BL; i++) step(0, 1, 16'($urandom), 0, 0, 0);
        step(0, 0, 16'h0, 0, 0, 0);
        check("t6_req_again", 32'(wr_req), 32'h1);
        check("t6_addr_again", 32'(wr_addr), 32'(BASE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
